// File: rtl/ram_reader.sv
// ram_reader: reads the sample RAM newest-first and
// streams each WIDTH-bit word out as bytes, LSB first.
module ram_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DEPTH-1:0] ptr_i,
  input  logic [DEPTH:0]   cnt_i,
  output logic             ram_en_o,
  output logic             ram_we_o,
  output logic [DEPTH-1:0] ram_addr_o,
  input  logic [WIDTH-1:0] ram_d_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NB = WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DEPTH:0] FULL =
    {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] REM_ONE =
    {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] ADDR_ONE =
    {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIDX_ONE =
    {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIDX_LAST =
    BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DEPTH-1:0] r_addr;
  logic [DEPTH:0]   r_rem;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bidx;

  logic             w_hs;
  logic             w_last;
  logic             w_zero;
  logic [DEPTH:0]   w_cnt_sat;

  // Counts of 2^DEPTH or more still read
  // every word exactly once.
  assign w_cnt_sat = cnt_i[DEPTH] ? FULL : cnt_i;
  assign w_zero    = (cnt_i == '0);
  assign w_hs      = tx_valid_o & tx_ready_i;
  assign w_last    = (r_bidx == BIDX_LAST);

  assign ram_we_o   = 1'b0;
  assign ram_addr_o = r_addr;
  assign tx_data_o  = r_shreg[7:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort overrides all.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = w_zero ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        w_next = S_LATCH;
      end
      S_LATCH: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs && w_last) begin
          w_next = (r_rem != '0) ? S_READ
                                 : S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort_i) begin
      w_next = S_IDLE;
    end
  end

  // Outputs decoded straight from state.
  always_comb begin
    ram_en_o   = 1'b0;
    tx_valid_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    unique case (r_state)
      S_IDLE:  busy_o     = 1'b0;
      S_READ:  ram_en_o   = 1'b1;
      S_LATCH: ;
      S_SEND:  tx_valid_o = 1'b1;
      S_DONE:  done_o     = 1'b1;
      default: busy_o     = 1'b1;
    endcase
  end

  // Address, remaining count and byte shifter.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_shreg <= '0;
      r_bidx  <= '0;
    end else if (!abort_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr <= ptr_i;
            r_rem  <= w_cnt_sat;
          end
        end
        S_LATCH: begin
          r_shreg <= ram_d_i;
          r_bidx  <= '0;
          r_rem   <= r_rem - REM_ONE;
          r_addr  <= r_addr - ADDR_ONE;
        end
        S_SEND: begin
          if (w_hs) begin
            r_shreg <= r_shreg >> 8;
            r_bidx  <= r_bidx + BIDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: scoreboard bench for ram_reader.
// Expected bytes/addresses queued at issue time.
module tb_ram_reader;

  localparam int W = 32;
  localparam int D = 5;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic         abort    = 1'b0;
  logic         tx_ready = 1'b1;
  logic [D-1:0] ptr      = '0;
  logic [D:0]   cnt      = '0;
  logic [W-1:0] ram_d    = '0;

  logic         ram_en;
  logic         ram_we;
  logic [D-1:0] ram_addr;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic         done;

  ram_reader #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .ptr_i      (ptr),
    .cnt_i      (cnt),
    .ram_en_o   (ram_en),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_d_i    (ram_d),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:31];

  always @(posedge clk) begin
    if (ram_en) ram_d <= mem[ram_addr];
  end

  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  logic rnd    = 1'b0;

  logic [7:0]   byte_q [$];
  logic [D-1:0] addr_q [$];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen in budget",
             nm);
  endtask

  // Monitor: pops and compares on every
  // RAM access and every accepted byte.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      chk("ram_we", ram_we, 0);
      if (ram_en) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ram_en: got addr 0x%0h, want none",
                   ram_addr);
        end else begin
          chk("ram_addr", ram_addr, addr_q.pop_front());
        end
      end
      if (pv && !pr && tx_valid)
        chk("hold_data", tx_data, pd);
      if (tx_valid && tx_ready) begin
        if (byte_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_byte: got 0x%0h, want none",
                   tx_data);
        end else begin
          chk("tx_byte", tx_data, byte_q.pop_front());
        end
      end
      if (done) n_done++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  // Ready driver: held high or randomly toggled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [D-1:0] a,
                           input int nb);
    addr_q.push_back(a);
    for (int k = 0; k < nb; k++)
      byte_q.push_back(8'(mem[a] >> (8 * k)));
  endtask

  task automatic push_basic();
    addr_q.push_back(5'd3);
    addr_q.push_back(5'd2);
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    byte_q.push_back(8'h33);
    byte_q.push_back(8'h44);
    byte_q.push_back(8'h55);
    byte_q.push_back(8'h66);
    byte_q.push_back(8'h77);
    byte_q.push_back(8'h88);
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_bytes_left"}, byte_q.size(), 0);
    chk({nm, "_addrs_left"}, addr_q.size(), 0);
  endtask

  // Start in cycle 0 and track the readout
  // until busy drops; ign pulses a stray start.
  task automatic run(input logic [D-1:0] p,
                     input logic [D:0] c,
                     input int ign,
                     output int fv,
                     output int dc,
                     output int bf,
                     output int nd);
    int d0;
    fv = -1;
    dc = -1;
    bf = -1;
    d0 = n_done;
    step();
    start = 1'b1;
    ptr   = p;
    cnt   = c;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (fv < 0 && tx_valid) fv = k;
      if (dc < 0 && done) dc = k;
      if (k > 0 && !busy) begin
        bf = k;
        break;
      end
      @(posedge clk);
      #1;
      start = (k + 1 == ign);
      if (start) begin
        ptr = 5'd7;
        cnt = 6'd5;
      end
    end
    start = 1'b0;
    if (bf < 0) fail("run_timeout");
    nd = n_done - d0;
  endtask

  task automatic wait_idle(input string nm);
    int ok;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) fail(nm);
  endtask

  int fv, dc, bf, nd, d0;

  initial begin
    for (int i = 0; i < 32; i++)
      mem[i] = {8'(4 * i + 3), 8'(4 * i + 2),
                8'(4 * i + 1), 8'(4 * i)};
    mem[3] = 32'h44332211;
    mem[2] = 32'h88776655;

    // Reset values, no clock edge yet.
    #2;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic readout.
    push_basic();
    run(5'd3, 6'd2, 0, fv, dc, bf, nd);
    chk("basic_first_valid", fv, 3);
    chk("basic_done_cycle", dc, 13);
    chk("basic_busy_fall", bf, 14);
    chk("basic_done_count", nd, 1);
    check_empty("basic");

    // Wrap-around through address 0.
    addr_q.push_back(5'd1);
    addr_q.push_back(5'd0);
    addr_q.push_back(5'd31);
    addr_q.push_back(5'd30);
    byte_q.push_back(8'h04);
    byte_q.push_back(8'h05);
    byte_q.push_back(8'h06);
    byte_q.push_back(8'h07);
    byte_q.push_back(8'h00);
    byte_q.push_back(8'h01);
    byte_q.push_back(8'h02);
    byte_q.push_back(8'h03);
    byte_q.push_back(8'h7C);
    byte_q.push_back(8'h7D);
    byte_q.push_back(8'h7E);
    byte_q.push_back(8'h7F);
    byte_q.push_back(8'h78);
    byte_q.push_back(8'h79);
    byte_q.push_back(8'h7A);
    byte_q.push_back(8'h7B);
    run(5'd1, 6'd4, 0, fv, dc, bf, nd);
    chk("wrap_done_cycle", dc, 25);
    chk("wrap_done_count", nd, 1);
    check_empty("wrap");

    // Back-pressure.
    rnd = 1'b1;
    push_basic();
    run(5'd3, 6'd2, 0, fv, dc, bf, nd);
    rnd = 1'b0;
    chk("bp_first_valid", fv, 3);
    chk("bp_done_count", nd, 1);
    check_empty("bp");
    step();

    // Zero count.
    run(5'd9, 6'd0, 0, fv, dc, bf, nd);
    chk("zero_done_cycle", dc, 1);
    chk("zero_busy_fall", bf, 2);
    chk("zero_no_valid", fv, -1);
    chk("zero_done_count", nd, 1);
    check_empty("zero");

    // Saturated count.
    for (int i = 0; i < 32; i++)
      push_word(5'd17 - 5'(i), 4);
    run(5'd17, 6'd40, 0, fv, dc, bf, nd);
    chk("sat_done_cycle", dc, 193);
    chk("sat_done_count", nd, 1);
    check_empty("sat");

    // Start ignored while busy.
    push_basic();
    run(5'd3, 6'd2, 4, fv, dc, bf, nd);
    chk("ign_done_cycle", dc, 13);
    chk("ign_done_count", nd, 1);
    check_empty("ign");

    // Abort on third byte of second word.
    push_word(5'd10, 4);
    push_word(5'd9, 3);
    d0 = n_done;
    step();
    start = 1'b1;
    ptr   = 5'd10;
    cnt   = 6'd3;
    step();
    start = 1'b0;
    repeat (9) step();
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cyc_valid", tx_valid, 1);
    step();
    abort = 1'b0;
    check_empty("abort");
    push_word(5'd5, 4);
    start = 1'b1;
    ptr   = 5'd5;
    cnt   = 6'd1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", tx_valid, 0);
    chk("abort_done", done, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_ram_en", ram_en, 1);
    wait_idle("restart_timeout");
    chk("abort_done_count", n_done - d0, 1);
    check_empty("restart");

    // Asynchronous reset mid-SEND.
    push_word(5'd20, 4);
    push_word(5'd19, 4);
    d0 = n_done;
    step();
    start = 1'b1;
    ptr   = 5'd20;
    cnt   = 6'd2;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    byte_q.delete();
    addr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done_count", n_done - d0, 0);
    push_word(5'd2, 4);
    run(5'd2, 6'd1, 0, fv, dc, bf, nd);
    chk("post_rst_done_cycle", dc, 7);
    chk("post_rst_count", nd, 1);
    check_empty("post_rst");

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
# ram_reader

Readout engine for the sample memory. After a capture, the control unit gives it the last written address and a sample count. It then reads the RAM interface backwards, newest sample first, and serializes each WIDTH-bit word into bytes on a valid/ready stream that feeds the UART transmitter. It is the read-side counterpart of the capture writer: it owns the RAM port during readout and never writes.

## Interface

Parameters:
- WIDTH, 32: sample width in bits; must be a multiple of 8.
- DEPTH, 5: RAM address width; the memory holds 2^DEPTH words.

Ports:
- clk_i, in, 1: system clock.
- rst_in, in, 1: reset. One clock; reset is asynchronous and active-low.
- start_i, in, 1: start readout. Sampled only in IDLE.
- abort_i, in, 1: synchronous abort; returns to IDLE from any state.
- ptr_i, in, DEPTH: address of the newest sample. Captured on start.
- cnt_i, in, DEPTH+1: number of samples to send. Captured on start.
- ram_en_o, out, 1: RAM enable.
- ram_we_o, out, 1: RAM write enable; tied to 0.
- ram_addr_o, out, DEPTH: RAM address.
- ram_d_i, in, WIDTH: RAM read data, valid one cycle after ram_en_o.
- tx_data_o, out, 8: byte to the transmitter.
- tx_valid_o, out, 1: byte valid.
- tx_ready_i, in, 1: transmitter accepts the byte.
- busy_o, out, 1: high whenever the state is not IDLE.
- done_o, out, 1: one-cycle pulse at the end of a completed readout.

## Operation

- States: IDLE, READ, LATCH, SEND, DONE.
- IDLE:
  - On start_i, load addr←ptr_i and rem←min(cnt_i, 2^DEPTH).
  - If cnt_i==0, go to DONE; otherwise go to READ.
  - Any start_i in a state other than IDLE is ignored.
- READ: ram_en_o=1, ram_addr_o=addr. Go to LATCH.
- LATCH:
  - shreg←ram_d_i, byte index←0, rem←rem-1, addr←addr-1.
  - The address decrement wraps modulo 2^DEPTH, so 0 becomes 2^DEPTH-1.
  - Go to SEND.
- SEND:
  - tx_valid_o=1, tx_data_o=shreg[7:0].
  - On tx_valid_o&tx_ready_i, shift shreg right by 8 and increment the byte index. Bytes go out LSB first.
  - After byte WIDTH/8-1 is accepted: go to READ if rem≠0, else go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- abort_i: takes priority over every other transition.
  - Next state is IDLE and tx_valid_o is 0 from the next cycle.
  - done_o does not pulse.
  - A byte already handshaken in the abort cycle counts as sent.
- Stream rule: while tx_valid_o is high and tx_ready_i is low, tx_data_o holds stable.
- Counter width: rem is DEPTH+1 bits. A cnt_i of 2^DEPTH or more reads the whole memory exactly once.

## Timing

- Reset values:
  - Outputs: ram_en_o=0, ram_we_o=0, ram_addr_o=0, tx_data_o=0, tx_valid_o=0, busy_o=0, done_o=0.
  - Internal: state IDLE, addr 0, rem 0, shreg 0.
- Reset mid-readout clears everything at once, asynchronously. No done_o pulse is produced.
- All outputs are registered or decoded directly from state and registers. There is no combinational path from tx_ready_i to any output.
- Start in cycle 0 gives READ in cycle 1 and LATCH in cycle 2. tx_valid_o is high with the first byte from cycle 3.
- With tx_ready_i held high, one sample takes 2+WIDTH/8 cycles (6 for WIDTH=32).
- done_o is high in the cycle after the last byte is accepted. busy_o falls one cycle later.
- cnt_i==0: busy_o is high for 1 cycle (DONE) and done_o pulses in cycle 1. No RAM access and no bytes.
- ram_en_o is high only in READ.

## Test plan

WIDTH=32, DEPTH=5 for all scenarios.

- Basic readout:
  - Stimulus: RAM[3]=0x44332211, RAM[2]=0x88776655, ptr_i=3, cnt_i=2, tx_ready_i=1.
  - Response: bytes 11 22 33 44 55 66 77 88; first tx_valid_o in cycle 3; done_o in cycle 13; ram_we_o=0 throughout.
- Wrap-around:
  - Stimulus: ptr_i=1, cnt_i=4.
  - Response: RAM addresses read in order 1, 0, 31, 30; 16 bytes; one done_o.
- Back-pressure:
  - Stimulus: tx_ready_i toggling randomly.
  - Response: tx_data_o stable while tx_valid_o is high and tx_ready_i low; no byte lost or duplicated; same byte order as basic readout.
- Zero and saturation:
  - Stimulus A: cnt_i=0. Response: done_o in cycle 1; no tx_valid_o; no ram_en_o.
  - Stimulus B: cnt_i=40. Response: exactly 32 words (128 bytes) from ptr_i downward.
- Abort and reset:
  - Stimulus: abort_i during the third byte of the second word.
  - Response: IDLE next cycle; tx_valid_o=0; no done_o; a new start_i is accepted in the cycle after.
  - Stimulus: rst_in low mid-SEND. Response: all outputs at reset values immediately, with no clock edge needed.
- Start ignored while busy:
  - Stimulus: pulse start_i with ptr_i=7 during a readout started with ptr_i=3.
  - Response: readout continues from 3; only one done_o.
